// File: rtl/fsk_demodulate.sv
// fsk_demodulate: recovers the 2-bit symbol from a square wave whose half-period
// (1, 2, 4 or 8 clk cycles) encodes the symbol. Edge-to-edge run lengths are
// measured and classified. A symbol is only published after CONFIRM consecutive
// runs agree. Carrier loss is declared after TIMEOUT cycles with no edge.
module fsk_demodulate #(
    parameter int CONFIRM = 4,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in,
    output logic [1:0] sym,
    output logic       valid,
    output logic       sym_stb,
    output logic       err,
    output logic       lost
);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Returns {ok, class}. ok=0 marks a run length that matches no symbol.
    function automatic logic [2:0] classify(input logic [CNT_W-1:0] len);
        if (len == CNT_W'(1))
            return 3'b100;
        else if (len == CNT_W'(2))
            return 3'b101;
        else if (len >= CNT_W'(3) && len <= CNT_W'(5))
            return 3'b110;
        else if (len >= CNT_W'(6) && len <= CNT_W'(11))
            return 3'b111;
        else
            return 3'b000;
    endfunction

    logic             s1_q, s2_q, s3_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           state_q;
    logic [1:0]       cand_q;
    logic [3:0]       ccnt_q;
    logic [1:0]       sym_q;
    logic             valid_q, stb_q, err_q, lost_q;

    logic             edge_w;
    logic [2:0]       cls_w;
    logic             run_ok;
    logic [1:0]       run_cls;
    logic [3:0]       ccnt_inc;
    logic             confirm_hit;
    logic             timeout_w;

    // The third flop only exists to give a clean edge detect; s1 absorbs metastability.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign edge_w = s2_q ^ s3_q;

    // Run-length counter: restarts at 1 on every edge, otherwise counts up and saturates.
    always_comb begin
        cnt_d = cnt_q;
        if (edge_w)
            cnt_d = CNT_W'(1);
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + CNT_W'(1);
    end

    // Holds the length of the run in progress; on an edge cycle it is the completed run length.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt_q <= CNT_W'(1);
        else
            cnt_q <= cnt_d;
    end

    assign cls_w       = classify(cnt_q);
    assign run_ok      = cls_w[2];
    assign run_cls     = cls_w[1:0];
    assign ccnt_inc    = (run_cls == cand_q) ? ccnt_q + 4'd1 : 4'd1;
    assign confirm_hit = (ccnt_inc == 4'(CONFIRM));
    assign timeout_w   = !edge_w && (cnt_q == CNT_W'(TIMEOUT)) && (state_q != HUNT);

    // Lock FSM with registered outputs; an edge always wins over a timeout in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= HUNT;
            cand_q  <= 2'd0;
            ccnt_q  <= 4'd0;
            sym_q   <= 2'd0;
            valid_q <= 1'b0;
            stb_q   <= 1'b0;
            err_q   <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            stb_q  <= 1'b0;
            err_q  <= 1'b0;
            lost_q <= 1'b0;
            if (edge_w) begin
                case (state_q)
                    HUNT: begin
                        // The run ending here started at an unknown point, so it is only a reference.
                        state_q <= ACQ;
                        ccnt_q  <= 4'd0;
                    end
                    ACQ, LOCK: begin
                        if (!run_ok) begin
                            err_q  <= 1'b1;
                            ccnt_q <= 4'd0;
                        end else if (state_q == LOCK && run_cls == sym_q) begin
                            ccnt_q <= 4'd0;
                        end else if (confirm_hit) begin
                            state_q <= LOCK;
                            sym_q   <= run_cls;
                            valid_q <= 1'b1;
                            stb_q   <= 1'b1;
                            ccnt_q  <= 4'd0;
                        end else begin
                            cand_q <= run_cls;
                            ccnt_q <= ccnt_inc;
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end else if (timeout_w) begin
                // sym keeps its last value so downstream can still see what was received.
                state_q <= HUNT;
                valid_q <= 1'b0;
                lost_q  <= 1'b1;
                cand_q  <= 2'd0;
                ccnt_q  <= 4'd0;
            end
        end
    end

    assign sym     = sym_q;
    assign valid   = valid_q;
    assign sym_stb = stb_q;
    assign err     = err_q;
    assign lost    = lost_q;

endmodule

// File: tb/tb_fsk_demodulate.sv
// Testbench for fsk_demodulate: scenario tasks plus a run-length based reference model.
module tb_fsk_demodulate;

    localparam int CONFIRM = 4;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 8;
    localparam int EV_N    = 65536;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       din   = 1'b0;
    logic [1:0] sym;
    logic       valid, sym_stb, err, lost;

    fsk_demodulate #(.CONFIRM(CONFIRM), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .in      (din),
        .sym     (sym),
        .valid   (valid),
        .sym_stb (sym_stb),
        .err     (err),
        .lost    (lost)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Expected output events, indexed by the rising-edge number after which they show.
    int ev_sym   [EV_N];
    int ev_valid [EV_N];
    bit ev_stb   [EV_N];
    bit ev_err   [EV_N];
    bit ev_lost  [EV_N];

    // Reference model: works on the times at which input transitions are sampled.
    typedef enum {M_HUNT, M_ACQ, M_LOCK} mstate_t;
    mstate_t m_state = M_HUNT;
    int m_sym = 0, m_cand = 0, m_cnt = 0, m_last = 0;
    int m_n_stb = 0, m_n_err = 0, m_n_lost = 0;

    // Observed-trace bookkeeping.
    logic prev_v = 1'b0;
    int   last_trans_p = 0;
    int   e_sym = 0, e_valid = 0;
    int   mon_mism = 0, mm_cyc = 0;
    logic [5:0] mm_act, mm_exp;
    int   n_stb = 0, n_err = 0, n_lost = 0;
    int   last_stb_cyc = 0, last_lost_cyc = 0;

    function automatic int classify_run(input int len);
        if (len == 1) return 0;
        if (len == 2) return 1;
        if (len >= 3 && len <= 5) return 2;
        if (len >= 6 && len <= 11) return 3;
        return -1;
    endfunction

    // p: rising edge that first samples the current input value; decisions show after edge p+2.
    task automatic model_step(input int p, input bit trans);
        int len, c, nc;
        if (trans) begin
            len    = p - m_last;
            m_last = p;
            if (m_state == M_HUNT) begin
                m_state = M_ACQ;
                m_cnt   = 0;
            end else begin
                c = classify_run(len);
                if (c < 0) begin
                    ev_err[p+2] = 1'b1;
                    m_n_err++;
                    m_cnt = 0;
                end else if (m_state == M_LOCK && c == m_sym) begin
                    m_cnt = 0;
                end else begin
                    nc     = (c == m_cand) ? m_cnt + 1 : 1;
                    m_cand = c;
                    if (nc == CONFIRM) begin
                        m_state       = M_LOCK;
                        m_sym         = c;
                        m_cnt         = 0;
                        ev_sym[p+2]   = c;
                        ev_valid[p+2] = 1;
                        ev_stb[p+2]   = 1'b1;
                        m_n_stb++;
                    end else begin
                        m_cnt = nc;
                    end
                end
            end
        end else if (m_state != M_HUNT && p - m_last == TIMEOUT) begin
            m_state       = M_HUNT;
            m_cnt         = 0;
            m_cand        = 0;
            ev_valid[p+2] = 0;
            ev_lost[p+2]  = 1'b1;
            m_n_lost++;
        end
    endtask

    task automatic monitor_sample();
        logic [5:0] act, expv;
        int c;
        c = cyc;
        if (ev_sym[c] >= 0)   e_sym   = ev_sym[c];
        if (ev_valid[c] >= 0) e_valid = ev_valid[c];
        act  = {sym, valid, sym_stb, err, lost};
        expv = {2'(e_sym), 1'(e_valid), ev_stb[c], ev_err[c], ev_lost[c]};
        if (act !== expv) begin
            if (mon_mism == 0) begin
                mm_cyc = c;
                mm_act = act;
                mm_exp = expv;
            end
            mon_mism++;
        end
        if (sym_stb === 1'b1) begin n_stb++;  last_stb_cyc  = c; end
        if (err === 1'b1)     n_err++;
        if (lost === 1'b1)    begin n_lost++; last_lost_cyc = c; end
    endtask

    // Called at a falling edge: holds din at v for n cycles.
    task automatic drive_hold(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            din = v;
            if (v != prev_v) last_trans_p = cyc + 1;
            model_step(cyc + 1, v != prev_v);
            prev_v = v;
            @(negedge clk);
            monitor_sample();
        end
    endtask

    task automatic toggle_runs(input int len, input int n);
        for (int i = 0; i < n; i++) drive_hold(~prev_v, len);
    endtask

    task automatic clear_events();
        for (int i = 0; i < EV_N; i++) begin
            ev_sym[i]   = -1;
            ev_valid[i] = -1;
            ev_stb[i]   = 1'b0;
            ev_err[i]   = 1'b0;
            ev_lost[i]  = 1'b0;
        end
    endtask

    task automatic report_trace(input string name, input int mm0);
        checks++;
        if (mon_mism !== mm0) begin
            errors++;
            $display("FAIL %s_trace: %0d cycle mismatches, first at cycle %0d got %b expected %b",
                     name, mon_mism - mm0, mm_cyc, mm_act, mm_exp);
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({sym, valid, sym_stb, err, lost} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", {sym, valid, sym_stb, err, lost}, 6'b0);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_acquire(input string tag);
        int s0, e0, mm0, p5;
        s0 = n_stb; e0 = n_err; mm0 = mon_mism;
        drive_hold(1'b0, 3);
        toggle_runs(8, 4);
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_prelock_valid: got %b expected 0", tag, valid);
        end
        toggle_runs(8, 1);
        p5 = last_trans_p;
        checks++;
        if (sym !== 2'd3 || valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_lock: got sym=%0d valid=%b expected sym=3 valid=1", tag, sym, valid);
        end
        checks++;
        if (n_stb - s0 !== 1) begin
            errors++;
            $display("FAIL %s_stb_count: got %0d expected 1", tag, n_stb - s0);
        end
        checks++;
        if (last_stb_cyc !== p5 + 2) begin
            errors++;
            $display("FAIL %s_latency: stb at edge %0d expected edge %0d", tag, last_stb_cyc, p5 + 2);
        end
        checks++;
        if (n_err - e0 !== 0) begin
            errors++;
            $display("FAIL %s_err_count: got %0d expected 0", tag, n_err - e0);
        end
        report_trace(tag, mm0);
    endtask

    task automatic test_switch_to_sym0();
        int s0, mm0;
        s0 = n_stb; mm0 = mon_mism;
        toggle_runs(1, 4);
        checks++;
        if (sym !== 2'd3 || n_stb - s0 !== 0) begin
            errors++;
            $display("FAIL sym0_hold: got sym=%0d stb=%0d expected sym=3 stb=0", sym, n_stb - s0);
        end
        toggle_runs(1, 4);
        checks++;
        if (sym !== 2'd0 || valid !== 1'b1 || n_stb - s0 !== 1) begin
            errors++;
            $display("FAIL sym0_switch: got sym=%0d valid=%b stb=%0d expected sym=0 valid=1 stb=1",
                     sym, valid, n_stb - s0);
        end
        report_trace("sym0", mm0);
    endtask

    task automatic test_glitch_sym2();
        int s0, mm0;
        mm0 = mon_mism;
        toggle_runs(4, 7);
        s0 = n_stb;
        checks++;
        if (sym !== 2'd2) begin
            errors++;
            $display("FAIL sym2_lock: got %0d expected 2", sym);
        end
        toggle_runs(2, 2);
        toggle_runs(4, 4);
        checks++;
        if (sym !== 2'd2 || n_stb - s0 !== 0) begin
            errors++;
            $display("FAIL sym2_glitch: got sym=%0d stb=%0d expected sym=2 stb=0", sym, n_stb - s0);
        end
        toggle_runs(2, 5);
        toggle_runs(2, 2);
        checks++;
        if (sym !== 2'd1 || n_stb - s0 !== 1) begin
            errors++;
            $display("FAIL sym2_to_1: got sym=%0d stb=%0d expected sym=1 stb=1", sym, n_stb - s0);
        end
        report_trace("glitch", mm0);
    endtask

    task automatic test_timeout();
        int l0, s0, mm0, q;
        l0 = n_lost; mm0 = mon_mism;
        q = last_trans_p;
        drive_hold(prev_v, 70);
        checks++;
        if (n_lost - l0 !== 1) begin
            errors++;
            $display("FAIL timeout_count: got %0d expected 1", n_lost - l0);
        end
        checks++;
        if (last_lost_cyc !== q + TIMEOUT + 2) begin
            errors++;
            $display("FAIL timeout_time: lost at edge %0d expected edge %0d", last_lost_cyc, q + TIMEOUT + 2);
        end
        checks++;
        if (valid !== 1'b0 || sym !== 2'd1) begin
            errors++;
            $display("FAIL timeout_state: got sym=%0d valid=%b expected sym=1 valid=0", sym, valid);
        end
        s0 = n_stb;
        toggle_runs(2, 6);
        checks++;
        if (sym !== 2'd1 || valid !== 1'b1 || n_stb - s0 !== 1) begin
            errors++;
            $display("FAIL reacquire: got sym=%0d valid=%b stb=%0d expected sym=1 valid=1 stb=1",
                     sym, valid, n_stb - s0);
        end
        report_trace("timeout", mm0);
    endtask

    task automatic test_err_inject();
        int s0, e0, mm0;
        s0 = n_stb; e0 = n_err; mm0 = mon_mism;
        toggle_runs(13, 1);
        toggle_runs(2, 3);
        checks++;
        if (n_err - e0 !== 1) begin
            errors++;
            $display("FAIL err_count: got %0d expected 1", n_err - e0);
        end
        checks++;
        if (sym !== 2'd1 || valid !== 1'b1 || n_stb - s0 !== 0) begin
            errors++;
            $display("FAIL err_state: got sym=%0d valid=%b stb=%0d expected sym=1 valid=1 stb=0",
                     sym, valid, n_stb - s0);
        end
        report_trace("err", mm0);
    endtask

    task automatic test_reset_mid();
        int mm0;
        mm0 = mon_mism;
        toggle_runs(8, 6);
        checks++;
        if (sym !== 2'd3 || valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: got sym=%0d valid=%b expected sym=3 valid=1", sym, valid);
        end
        report_trace("midreset_pre", mm0);
        drive_hold(~prev_v, 3);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({sym, valid, sym_stb, err, lost} !== 6'b0) begin
            errors++;
            $display("FAIL midreset_async: got %b expected %b", {sym, valid, sym_stb, err, lost}, 6'b0);
        end
        din    = 1'b0;
        prev_v = 1'b0;
        @(negedge clk);
        @(negedge clk);
        m_state = M_HUNT;
        m_sym   = 0;
        m_cand  = 0;
        m_cnt   = 0;
        e_sym   = 0;
        e_valid = 0;
        for (int i = cyc; i < cyc + 6; i++) begin
            ev_sym[i] = -1; ev_valid[i] = -1;
            ev_stb[i] = 1'b0; ev_err[i] = 1'b0; ev_lost[i] = 1'b0;
        end
        reset = 1'b1;
        test_acquire("after_reset");
    endtask

    task automatic test_random();
        int mm0, s0, e0, l0, ms0, me0, ml0, k, r, len;
        mm0 = mon_mism; s0 = n_stb; e0 = n_err; l0 = n_lost;
        ms0 = m_n_stb; me0 = m_n_err; ml0 = m_n_lost;
        for (int seg = 0; seg < 300; seg++) begin
            k = $urandom_range(0, 3);
            r = $urandom_range(1, 6);
            for (int j = 0; j < r; j++) begin
                case (k)
                    0:       len = 1;
                    1:       len = 2;
                    2:       len = $urandom_range(3, 5);
                    default: len = $urandom_range(6, 11);
                endcase
                if ($urandom_range(0, 99) < 8)  len = $urandom_range(12, 20);
                if ($urandom_range(0, 99) < 2)  len = $urandom_range(60, 90);
                drive_hold(~prev_v, len);
            end
        end
        drive_hold(prev_v, 4);
        checks++;
        if (n_stb - s0 !== m_n_stb - ms0) begin
            errors++;
            $display("FAIL random_stb: got %0d expected %0d", n_stb - s0, m_n_stb - ms0);
        end
        checks++;
        if (n_err - e0 !== m_n_err - me0) begin
            errors++;
            $display("FAIL random_err: got %0d expected %0d", n_err - e0, m_n_err - me0);
        end
        checks++;
        if (n_lost - l0 !== m_n_lost - ml0) begin
            errors++;
            $display("FAIL random_lost: got %0d expected %0d", n_lost - l0, m_n_lost - ml0);
        end
        report_trace("random", mm0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_events();
        test_reset();
        test_acquire("acquire");
        test_switch_to_sym0();
        test_glitch_sym2();
        test_timeout();
        test_err_inject();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsk_demodulate.md
Name: fsk_demodulate

Overview:
- Receive-side counterpart of the clock-divider frequency-shift modulator. Recovers the 2-bit symbol from a square wave whose half-period encodes the symbol: 1, 2, 4 or 8 clk cycles for symbols 0, 1, 2 and 3.
- Measures edge-to-edge run lengths, classifies each run, and requires CONFIRM consecutive agreeing runs before publishing a symbol.
- Sits after the channel in the same clk domain; the input is still treated as asynchronous.

Parameters:
- CONFIRM, 4: consecutive identical classifications required to acquire lock or change symbol (range 1..15).
- TIMEOUT, 64: clk cycles without an input edge before carrier is declared lost (must be >11 and <2^CNT_W).
- CNT_W, 8: width of the run-length counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in  in  1  modulated square wave.
- sym  out  2  recovered symbol.
- valid  out  1  high while locked.
- sym_stb  out  1  one-cycle pulse when sym is (re)published.
- err  out  1  one-cycle pulse on an unclassifiable run.
- lost  out  1  one-cycle pulse on carrier timeout.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; sync flops 0; cnt=1; candidate class and count 0; state HUNT.
- Synchroniser: `in`→s1→s2→s3. edge = s2 XOR s3.
- Run counter:
  - On an edge cycle, L = cnt, then cnt ← 1.
  - Otherwise cnt increments, saturating at 2^CNT_W−1.
- Classification of L:
  - 1→0, 2→1, 3..5→2, 6..11→3.
  - 0 or ≥12 → invalid.
- FSM states: HUNT, ACQ, LOCK.
- HUNT: first edge only establishes a reference; L is discarded → ACQ, candidate count 0.
- ACQ, valid L:
  - If class equals the candidate, count+1; otherwise candidate←class, count←1.
  - When count reaches CONFIRM → LOCK; sym←candidate, valid←1, sym_stb pulse.
- ACQ, invalid L: err pulse, count←0, stay in ACQ.
- LOCK, valid L:
  - class==sym: candidate count cleared.
  - class≠sym: candidate counted as in ACQ; at CONFIRM, sym←class, sym_stb pulse, count cleared, stay in LOCK.
- LOCK, invalid L: err pulse, candidate count cleared, sym and valid unchanged.
- Timeout: in ACQ or LOCK, when there is no edge and cnt reaches TIMEOUT:
  - → HUNT; valid←0; lost pulse.
  - sym holds its last value; candidate cleared.
  - No lost pulse is issued from HUNT.
- Simultaneous events: an edge takes priority over timeout in the same cycle.
- Outputs: all outputs registered. sym_stb, err and lost are never high for more than one cycle each.
- Latency: a transition of `in` that completes a qualifying run appears on the outputs after the 3rd rising clk edge. That edge count includes the edge that first samples the transition into s1.
- Reset mid-operation: outputs drop to 0 immediately and the FSM restarts in HUNT; any partial run is discarded.
- Synchronous-sampling note: input toggling every clk (symbol 0) passes the synchroniser unchanged and yields L=1 consistently.

Test Plan:
- Reset release, `in` toggles every 8 clk → first edge discarded; sym=3, valid=1 and one sym_stb after the 5th edge (CONFIRM=4); no err.
- Locked at 3, switch to toggle every clk → sym stays 3 for 3 runs; 4th L=1 gives sym=0 and a single sym_stb; valid stays 1.
- Locked at 2 (L=4), insert two L=2 runs then resume L=4 → no sym_stb, sym=2 throughout; then four L=2 runs → sym=1, sym_stb once.
- Locked, hold `in` constant for 70 clk → lost pulse exactly when cnt reaches 64; valid=0; sym held. Resuming L=2 toggling reacquires sym=1 after 5 edges.
- Locked at 1, inject one run of L=13 → single err pulse; sym=1 and valid=1 unchanged; no sym_stb.
- Assert reset mid-run while locked at 3 → sym=0, valid=0 immediately without a clk edge. After release, behaviour matches the first scenario.
